// File: rtl/clock_divider_multi_if.sv
// Control/status bundle for clock_divider_multi.
// master: programs enables and divisor writes and observes the outputs.
// slave : the divider itself.
// Signals: enable, div_wr, div_ch, div_val (to divider);
//          clk_out, tick, pending, wr_err (from divider).
interface clock_divider_multi_if #(
    parameter int unsigned CHANNELS  = 2,
    parameter int unsigned DIV_WIDTH = 16
);
    localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0]  enable;
    logic                 div_wr;
    logic [CH_W-1:0]      div_ch;
    logic [DIV_WIDTH-1:0] div_val;
    logic [CHANNELS-1:0]  clk_out;
    logic [CHANNELS-1:0]  tick;
    logic [CHANNELS-1:0]  pending;
    logic                 wr_err;

    modport master (
        output enable, div_wr, div_ch, div_val,
        input  clk_out, tick, pending, wr_err
    );

    modport slave (
        input  enable, div_wr, div_ch, div_val,
        output clk_out, tick, pending, wr_err
    );
endinterface

// File: rtl/clock_divider_multi.sv
// Multi-channel 50%-duty clock divider with rising-edge tick strobes.
// Each channel divides clk_in by 2*N, where N is a runtime-programmable
// half-period divisor; new divisors are held pending and applied only at a
// half-period boundary so no runt pulses appear.
// Ports:
//   clk_in - sole clock, rising edge
//   reset  - synchronous, active-high
//   bus    - clock_divider_multi_if.slave (enable, div_wr/div_ch/div_val in;
//            clk_out, tick, pending, wr_err out, all registered)
module clock_divider_multi #(
    parameter int unsigned CHANNELS    = 2,
    parameter int unsigned DIV_WIDTH   = 16,
    parameter int unsigned DEFAULT_DIV = 5
) (
    input  logic                  clk_in,
    input  logic                  reset,
    clock_divider_multi_if.slave  bus
);
    localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [DIV_WIDTH-1:0] DEF_DIV = DIV_WIDTH'(DEFAULT_DIV);

    logic [DIV_WIDTH-1:0] cnt        [CHANNELS];
    logic [DIV_WIDTH-1:0] active_div [CHANNELS];
    logic [DIV_WIDTH-1:0] pend_div   [CHANNELS];
    logic [CHANNELS-1:0]  clk_out_q;
    logic [CHANNELS-1:0]  tick_q;
    logic [CHANNELS-1:0]  pending_q;
    logic                 wr_err_q;

    logic                 wr_ok_c;
    logic                 wr_bad_c;
    logic [CHANNELS-1:0]  wrap_c;
    logic [CHANNELS-1:0]  wr_sel_c;

    // Write qualification and per-channel half-period boundary detection
    always_comb begin
        wr_ok_c  = 1'b0;
        wr_bad_c = 1'b0;
        wrap_c   = '0;
        wr_sel_c = '0;
        wr_ok_c  = bus.div_wr && (bus.div_val != '0) && (32'(bus.div_ch) < CHANNELS);
        wr_bad_c = bus.div_wr && !wr_ok_c;
        for (int i = 0; i < CHANNELS; i++) begin
            wrap_c[i]   = (cnt[i] == active_div[i] - DIV_WIDTH'(1));
            wr_sel_c[i] = wr_ok_c && (bus.div_ch == CH_W'(i));
        end
    end

    // Channel counters, output clocks, ticks and divisor bookkeeping
    always_ff @(posedge clk_in) begin
        if (reset) begin
            clk_out_q <= '0;
            tick_q    <= '0;
            pending_q <= '0;
            wr_err_q  <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i]        <= '0;
                active_div[i] <= DEF_DIV;
                pend_div[i]   <= DEF_DIV;
            end
        end else begin
            wr_err_q <= wr_bad_c;
            for (int i = 0; i < CHANNELS; i++) begin
                if (!bus.enable[i]) begin
                    cnt[i]       <= '0;
                    clk_out_q[i] <= 1'b0;
                    tick_q[i]    <= 1'b0;
                end else if (wrap_c[i]) begin
                    cnt[i]       <= '0;
                    clk_out_q[i] <= ~clk_out_q[i];
                    tick_q[i]    <= ~clk_out_q[i];
                    // Wrap consumes the pending value seen before any same-cycle write
                    if (pending_q[i]) begin
                        active_div[i] <= pend_div[i];
                        pending_q[i]  <= 1'b0;
                    end
                end else begin
                    cnt[i]    <= cnt[i] + DIV_WIDTH'(1);
                    tick_q[i] <= 1'b0;
                end
                // A same-cycle write wins over the clear above and stays pending
                if (wr_sel_c[i]) begin
                    pend_div[i]  <= bus.div_val;
                    pending_q[i] <= 1'b1;
                end
            end
        end
    end

    assign bus.clk_out = clk_out_q;
    assign bus.tick    = tick_q;
    assign bus.pending = pending_q;
    assign bus.wr_err  = wr_err_q;
endmodule
